// File: rtl/serial_rx.sv
// UART receiver (8N1, LSB first, idle high) with mid-bit sampling and framing-error flag.
// Optional even-parity checking is compiled in with SERIAL_RX_PARITY_EN.
module serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 fpga_clock,
   input  logic                 reset_n,
   input  logic                 rx,
   input  logic                 enable,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 busy,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 db_sample
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_END,
      S_WAIT_IDLE
   } state_t;

   state_t               r_state;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_rx_prev;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_stop_bit;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_done;
   logic                 r_busy;
   logic                 r_ferr;
   logic                 r_db;

   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_stop_nxt;
   logic [DATA_BITS-1:0] w_data_nxt;
   logic                 w_done_nxt;
   logic                 w_busy_nxt;
   logic                 w_ferr_nxt;
   logic                 w_db_nxt;
   logic                 w_cnt_last;
   logic                 w_cnt_half;

`ifdef SERIAL_RX_PARITY_EN
   logic r_par_bit;
   logic r_perr;
   logic w_par_nxt;
   logic w_perr_nxt;
`endif

   assign w_cnt_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_cnt_half = (r_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));

   // Two-flop synchroniser plus previous-sample flop for falling-edge detection
   always_ff @(posedge fpga_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   always_ff @(posedge fpga_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_stop_bit <= 1'b1;
         r_data     <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_ferr     <= 1'b0;
         r_db       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_stop_bit <= w_stop_nxt;
         r_data     <= w_data_nxt;
         r_done     <= w_done_nxt;
         r_busy     <= w_busy_nxt;
         r_ferr     <= w_ferr_nxt;
         r_db       <= w_db_nxt;
      end
   end

`ifdef SERIAL_RX_PARITY_EN
   always_ff @(posedge fpga_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_par_bit <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         r_par_bit <= w_par_nxt;
         r_perr    <= w_perr_nxt;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_stop_nxt  = r_stop_bit;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_db_nxt    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      w_par_nxt   = r_par_bit;
      w_perr_nxt  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (enable && !r_rx_s && r_rx_prev) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_cnt_half) begin
               w_db_nxt = 1'b1;
               if (!r_rx_s) begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_cnt_last) begin
               w_db_nxt    = 1'b1;
               w_shift_nxt = (r_shift >> 1) | (DATA_BITS'(r_rx_s) << (DATA_BITS - 1));
               if (r_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_last) begin
               w_db_nxt    = 1'b1;
               w_par_nxt   = r_rx_s;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_cnt_last) begin
               w_db_nxt    = 1'b1;
               w_stop_nxt  = r_rx_s;
               w_state_nxt = S_END;
            end
         end
         S_END: begin
            // Publish the frame; a low stop bit parks in WAIT_IDLE so a break cannot re-trigger
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_data_nxt  = r_shift;
            w_ferr_nxt  = !r_stop_bit;
`ifdef SERIAL_RX_PARITY_EN
            w_perr_nxt  = (^r_shift) ^ r_par_bit;
`endif
            w_state_nxt = r_stop_bit ? S_IDLE : S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            w_cnt_nxt = '0;
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      // busy covers the done cycle and drops on the following one
      w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_END);
   end

   assign data        = r_data;
   assign done        = r_done;
   assign busy        = r_busy;
   assign frame_error = r_ferr;
   assign db_sample   = r_db;
`ifdef SERIAL_RX_PARITY_EN
   assign parity_error = r_perr;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Randomised self-checking bench for serial_rx against a frame-level expectation queue.
// Honours SERIAL_RX_PARITY_EN when the design is built with it.
module tb_serial_rx;

   localparam int unsigned CPB = 16;
   localparam int unsigned DB  = 8;
`ifdef SERIAL_RX_PARITY_EN
   localparam int unsigned PAR_BITS = 1;
`else
   localparam int unsigned PAR_BITS = 0;
`endif
   localparam int LAT    = 2 + 1 + CPB / 2 + (DB + 1) * CPB + 1 + PAR_BITS * CPB;
   localparam int N_SAMP = DB + 2 + PAR_BITS;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rx;
   logic          enable;
   logic [DB-1:0] data;
   logic          done;
   logic          busy;
   logic          frame_error;
   logic          parity_error;
   logic          db_sample;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      int         t0;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   db_cnt  = 0;
   logic busy_q  = 1'b0;
   logic done_q  = 1'b0;
   logic ferr_q  = 1'b0;

   serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) u_dut (
      .fpga_clock   (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .enable       (enable),
      .data         (data),
      .done         (done),
      .busy         (busy),
      .frame_error  (frame_error),
      .parity_error (parity_error),
      .db_sample    (db_sample)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Hold rx at v for n bit periods; tasks start and end 1 time unit after a rising edge
   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n * CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                             input bit expect_rx, input bit par_flip, input bit drop_en);
      exp_t e;
      logic pbit;
      pbit = (^b) ^ par_flip;
      if (expect_rx) begin
         e.d  = b;
         e.fe = !stop_v;
         e.pe = (PAR_BITS != 0) && ((($countones(b) + int'(pbit)) % 2) == 1);
         e.t0 = cyc;
         exp_q.push_back(e);
      end
      drive_bit(1'b0, 1);
      if (drop_en) enable = 1'b0;
      for (int i = 0; i < int'(DB); i++) drive_bit(b[i], 1);
      if (PAR_BITS != 0) drive_bit(pbit, 1);
      drive_bit(stop_v, stop_len);
   endtask

   // Monitor: compares every completed frame with the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (busy && !busy_q) db_cnt = 0;
      if (db_sample) db_cnt++;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("data", data, e.d);
            check("frame_error", frame_error, e.fe);
            check("parity_error", parity_error, e.pe);
            check("latency_window", (cyc - e.t0 >= LAT - 1) && (cyc - e.t0 <= LAT + 1), 1);
            check("db_sample_count", db_cnt, N_SAMP);
            check("busy_at_done", busy, 1);
         end
      end else if (frame_error || parity_error) begin
         check("error_without_done", 1, 0);
      end
      if (done_q && !ferr_q) check("busy_after_done", busy, 0);
      busy_q = busy;
      done_q = done;
      ferr_q = frame_error;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       sv;
      reset_n = 1'b0;
      rx      = 1'b1;
      enable  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", data, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", frame_error, 0);
      check("rst_perr", parity_error, 0);
      check("rst_db", db_sample, 0);
      reset_n = 1'b1;
      drive_bit(1'b1, 2);

      // Directed single frame, then 0x00/0xFF back to back
      send_frame(8'hA5, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 2);
      send_frame(8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 2);

      // Random frames with random gaps; occasional bad stop bit followed by idle
      for (int k = 0; k < 24; k++) begin
         b  = 8'($urandom);
         sv = ($urandom_range(0, 7) != 0);
         send_frame(b, sv, 1, 1'b1, 1'b0, 1'b0);
         drive_bit(1'b1, sv ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
      end
      drive_bit(1'b1, 2);

      // Short glitch: a false start that must be rejected at the mid-bit check
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("glitch_busy_high", busy, 1);
      repeat (20) @(posedge clk);
      #1;
      check("glitch_busy_low", busy, 0);
      check("glitch_db_count", db_cnt, 1);

      // Break on the stop bit: error reported once, busy held until the line recovers
      send_frame(8'h3C, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      check("break_busy", busy, 1);
      drive_bit(1'b1, 3);
      check("break_recovered", busy, 0);

      // Start edge while disabled, enable rising during the low level
      enable = 1'b0;
      rx     = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      enable = 1'b1;
      drive_bit(1'b0, 3);
      check("disabled_edge_busy", busy, 0);
      drive_bit(1'b1, 2);
      enable = 1'b0;
      send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 2);
      check("disabled_frame_busy", busy, 0);
      enable = 1'b1;
      send_frame(8'h81, 1'b1, 1, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 2);
      enable = 1'b1;

      // Reset in the middle of the data bits
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 1);
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 1);
      reset_n = 1'b0;
      #1;
      check("midrst_data", data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_db", db_sample, 0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive_bit(1'b1, 2);
      send_frame(8'h55, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 2);

`ifdef SERIAL_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 2);
      send_frame(8'h07, 1'b1, 1, 1'b1, 1'b1, 1'b0);
      drive_bit(1'b1, 2);
`endif

      drive_bit(1'b1, 4);
      check("pending_frames", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
